// File: rtl/pulse_delay_pkg.sv
// pulse_delay_pkg: shared mode encoding and delay clamp for the pulse delay filter
package pulse_delay_pkg;
  typedef enum logic {
    MODE_TRANSPORT = 1'b0,
    MODE_INERTIAL  = 1'b1
  } mode_e;
  function automatic int clamp_delay(input int req, input int dmax);
    return req < 1 ? 1 : (req > dmax ? dmax : req);
  endfunction
endpackage

// File: rtl/pulse_delay_chan.sv
// pulse_delay_chan: one channel; ports clk/rst, din, shared mode/delay/clr, registered dout/lost
module pulse_delay_chan
  import pulse_delay_pkg::*;
#(
  parameter int DELAY_MAX = 32,
  parameter int DW        = $clog2(DELAY_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  mode_e         mode,
  input  logic [DW-1:0] delay,
  input  logic          clr,
  output logic          dout,
  output logic          lost
);
  localparam int IW = $clog2(DELAY_MAX);
  logic [DELAY_MAX-1:0] sr_q, sr_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx;
  logic dout_q, dout_d, lost_q, lost_d, diff, ripe, fire, inert;
  always_comb begin
    sr_d   = {sr_q[DELAY_MAX-2:0], din};
    idx    = IW'(delay - DW'(1));
    inert  = mode == MODE_INERTIAL;
    diff   = sr_q[0] != dout_q;
    ripe   = cnt_q == delay - DW'(1);
    fire   = !clr && diff && ripe;
    dout_d = !inert ? sr_q[idx] : (fire ? sr_q[0] : dout_q);
    cnt_d  = (!inert || clr || !diff || ripe) ? '0 : cnt_q + DW'(1);
    lost_d = inert && !clr && !diff && cnt_q != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      lost_q <= lost_d;
    end
  end
  assign dout = dout_q;
  assign lost = lost_q;
endmodule

// File: rtl/pulse_delay_filter.sv
// pulse_delay_filter: multi-channel transport/inertial delay; ports clk/rst, din, cfg_*, dout/lost_pulse, cur_*
module pulse_delay_filter
  import pulse_delay_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DELAY_MAX   = 32,
  parameter int DELAY_RESET = 4,
  parameter int DW          = $clog2(DELAY_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  input  logic                cfg_load,
  input  logic                cfg_mode,
  input  logic [DW-1:0]       cfg_delay,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] lost_pulse,
  output logic [DW-1:0]       cur_delay,
  output logic                cur_mode
);
  mode_e mode_q, mode_d;
  logic [DW-1:0] delay_q, delay_d;
  logic upd_q, upd_d;
  always_comb begin
    mode_d  = cfg_load ? mode_e'(cfg_mode) : mode_q;
    delay_d = cfg_load ? DW'(clamp_delay(int'(cfg_delay), DELAY_MAX)) : delay_q;
    upd_d   = cfg_load;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_TRANSPORT;
      delay_q <= DW'(DELAY_RESET);
      upd_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      delay_q <= delay_d;
      upd_q   <= upd_d;
    end
  end
  // upd_q marks the first edge running under a freshly loaded config
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_delay_chan #(.DELAY_MAX(DELAY_MAX), .DW(DW)) u_chan (
      .clk  (clk),
      .rst  (rst),
      .din  (din[i]),
      .mode (mode_q),
      .delay(delay_q),
      .clr  (upd_q),
      .dout (dout[i]),
      .lost (lost_pulse[i])
    );
  end
  assign cur_delay = delay_q;
  assign cur_mode  = mode_q;
endmodule

// File: tb/tb_pulse_delay_filter.sv
// tb_pulse_delay_filter: randomized and directed scoreboard bench against a sample-history model
module tb_pulse_delay_filter;
  localparam int CH = 4, DM = 32, DR = 4, DW = 6, HN = 4096;
  logic clk = 1'b0, rst, cfg_load, cfg_mode;
  logic [CH-1:0] din, dout, lost_pulse;
  logic [DW-1:0] cfg_delay, cur_delay;
  logic cur_mode;
  always #5 clk = ~clk;
  pulse_delay_filter #(.CHANNELS(CH), .DELAY_MAX(DM), .DELAY_RESET(DR)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .cfg_load  (cfg_load),
    .cfg_mode  (cfg_mode),
    .cfg_delay (cfg_delay),
    .dout      (dout),
    .lost_pulse(lost_pulse),
    .cur_delay (cur_delay),
    .cur_mode  (cur_mode)
  );
  typedef struct packed {
    logic [CH-1:0] dout;
    logic [CH-1:0] lost;
    logic [DW-1:0] dly;
    logic          mode;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  logic [CH-1:0] hist[0:HN-1];
  int n = 0, r_last = -1, c_m = 0, d_m = DR;
  logic m_m = 1'b0;
  logic [CH-1:0] dout_m = '0;
  function automatic logic [CH-1:0] smp(input int i);
    return (i < 0 || i <= r_last || i >= HN) ? '0 : hist[i];
  endfunction
  task automatic model_edge();
    exp_t e;
    logic [CH-1:0] dn, ls, sv, s1, s2, tap;
    logic ok;
    int cd;
    ls = '0;
    if (rst) begin
      r_last = n;
      dout_m = '0;
      m_m    = 1'b0;
      d_m    = DR;
      c_m    = n + 1;
    end else begin
      if (n < HN) hist[n] = din;
      dn  = dout_m;
      tap = smp(n - d_m);
      s1  = smp(n - 1);
      s2  = smp(n - 2);
      for (int ch = 0; ch < CH; ch++) begin
        if (!m_m) dn[ch] = tap[ch];
        else begin
          ok = (n - d_m) >= c_m;
          for (int j = 1; j <= d_m; j++) begin
            sv = smp(n - j);
            if (sv[ch] == dout_m[ch]) ok = 1'b0;
          end
          if (ok) dn[ch] = ~dout_m[ch];
          ls[ch] = (n - 2 >= c_m) && s2[ch] != dout_m[ch] && s1[ch] == dout_m[ch];
        end
      end
      dout_m = dn;
      if (cfg_load) begin
        cd  = int'(cfg_delay);
        m_m = cfg_mode;
        d_m = cd == 0 ? 1 : (cd > DM ? DM : cd);
        c_m = n + 1;
      end
    end
    e = '{dout_m, ls, DW'(d_m), m_m};
    q.push_back(e);
    n++;
  endtask
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = '{dout, lost_pulse, cur_delay, cur_mode};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t dout=%b lost=%b dly=%0d mode=%b expected dout=%b lost=%b dly=%0d mode=%b",
                 $time, a.dout, a.lost, a.dly, a.mode, e.dout, e.lost, e.dly, e.mode);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic idle(input int k);
    repeat (k) tick();
  endtask
  task automatic load(input logic m, input int dl);
    cfg_load  = 1'b1;
    cfg_mode  = m;
    cfg_delay = DW'(dl);
    tick();
    cfg_load  = 1'b0;
  endtask
  task automatic pulse(input int ch, input int w, input int gap);
    din[ch] = 1'b1;
    idle(w);
    din[ch] = 1'b0;
    idle(gap);
  endtask
  initial begin
    int w[CH];
    rst = 1'b1; cfg_load = 1'b0; cfg_mode = 1'b0; cfg_delay = '0; din = '0;
    idle(2);
    rst = 1'b0;
    idle(10);
    load(1'b0, 20);
    idle(3);
    pulse(0, 35, 25);
    pulse(1, 1, 25);
    load(1'b1, 5);
    idle(3);
    pulse(0, 3, 12);
    pulse(0, 5, 12);
    pulse(0, 4, 12);
    pulse(1, 1, 1);
    pulse(1, 1, 1);
    pulse(1, 2, 12);
    load(1'b0, 0);
    idle(3);
    pulse(2, 1, 5);
    load(1'b0, 40);
    pulse(2, 2, 40);
    load(1'b1, 5);
    idle(5);
    din[0] = 1'b1;
    idle(3);
    load(1'b1, 8);
    idle(15);
    din[0] = 1'b0;
    idle(20);
    load(1'b0, 10);
    pulse(3, 3, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(20);
    load(1'b1, 5);
    idle(3);
    w = '{2, 4, 5, 7};
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < CH; i++) din[i] = t < w[i];
      tick();
    end
    idle(15);
    load(1'b1, 1);
    for (int t = 0; t < 20; t++) begin
      din = CH'($urandom);
      tick();
    end
    for (int t = 0; t < 900; t++) begin
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
      cfg_load  = $urandom_range(0, 39) == 0;
      cfg_mode  = 1'($urandom);
      cfg_delay = DW'($urandom_range(0, 40));
      rst       = $urandom_range(0, 199) == 0;
      tick();
      cfg_load = 1'b0;
      rst      = 1'b0;
    end
    idle(3);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
